// File: rtl/mixer_n.sv
// Multi-channel sampled-audio mixer with 1-bit effect sources and
// first-order sigma-delta outputs for left and right.
//
// Each mix period is SAMPLE_DIV clk28 cycles long. Phase 0 snapshots the
// inputs and seeds both accumulators with the 1-bit source levels.
// Phases 1..CHANNELS add one scaled channel each. Phase CHANNELS+1
// clamps the sums into the output levels. Each output level then drives
// its own sigma-delta modulator on every cycle.

// First-order sigma-delta modulator. The output bit is the carry out of
// sd + level, so the density of ones over 2^OUT_W cycles equals level.
module mixer_sd #(
  parameter int OUT_W = 10
) (
  input  logic             clk28,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] level,
  output logic             dac
);
  logic [OUT_W-1:0] sd;
  logic [OUT_W:0]   sum;

  assign sum = {1'b0, sd} + {1'b0, level};

  // Keep the low bits as the error term and register the carry as the output bit.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      sd  <= '0;
      dac <= 1'b0;
    end else begin
      sd  <= sum[OUT_W-1:0];
      dac <= sum[OUT_W];
    end
  end
endmodule

module mixer_n #(
  parameter int CHANNELS     = 4,
  parameter int SAMPLE_W     = 8,
  parameter int VOL_W        = 4,
  parameter int OUT_W        = 10,
  parameter int SAMPLE_DIV   = 512,
  parameter int BEEPER_LVL   = 128,
  parameter int TAPE_OUT_LVL = 32,
  parameter int TAPE_IN_LVL  = 32
) (
  input  logic                         clk28,
  input  logic                         rst_n,
  input  logic [CHANNELS*SAMPLE_W-1:0] ch_data,
  input  logic [CHANNELS*VOL_W-1:0]    ch_vol,
  input  logic [CHANNELS*2-1:0]        ch_pan,
  input  logic                         beeper,
  input  logic                         tape_out,
  input  logic                         tape_in,
  input  logic                         mute,
  output logic                         dac_l,
  output logic                         dac_r,
  output logic                         sample_strobe,
  output logic                         clip_l,
  output logic                         clip_r
);
  localparam int PH_W   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 2;
  localparam int ACC_A  = OUT_W + 1;
  localparam int ACC_B  = SAMPLE_W + $clog2(CHANNELS + 3) + 1;
  localparam int ACC_W  = (ACC_A > ACC_B) ? ACC_A : ACC_B;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LATCH = PH_W'(CHANNELS + 1);
  localparam logic [ACC_W-1:0] ACC_TOP  = ACC_W'((1 << OUT_W) - 1);
  localparam logic [OUT_W-1:0] LVL_TOP  = '1;

  // The channel schedule must fit inside one mix period.
  if (CHANNELS + 2 > SAMPLE_DIV) begin : g_bad_div
    $error("mixer_n: SAMPLE_DIV must be at least CHANNELS+2");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_ch
    $error("mixer_n: CHANNELS must be within 1..8");
  end

  logic [PH_W-1:0]                    phase;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  snap_data;
  logic [CHANNELS-1:0][VOL_W-1:0]     snap_vol;
  logic [CHANNELS-1:0][1:0]           snap_pan;
  logic                               snap_mute;
  logic [1:0][ACC_W-1:0]              acc;
  logic [1:0][OUT_W-1:0]              level;
  logic [1:0]                         clip;
  logic [1:0]                         dac;

  logic [SAMPLE_W-1:0] sel_data;
  logic [VOL_W-1:0]    sel_vol;
  logic [1:0]          sel_pan;
  logic [VOL_W:0]      gain;
  logic [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]    term;
  logic [ACC_W-1:0]    src;

  // Free-running phase counter that sets the mix period.
  always_ff @(posedge clk28) begin
    if (!rst_n)                phase <= '0;
    else if (phase == PH_LAST) phase <= '0;
    else                       phase <= phase + PH_W'(1);
  end

  // Freeze the channel state at phase 0 so the rest of the period is stable.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      snap_data <= '0;
      snap_vol  <= '0;
      snap_pan  <= '0;
      snap_mute <= 1'b0;
    end else if (phase == '0) begin
      snap_data <= ch_data;
      snap_vol  <= ch_vol;
      snap_pan  <= ch_pan;
      snap_mute <= mute;
    end
  end

  // Select channel phase-1. Outside phases 1..CHANNELS the pan stays 0, so nothing is added.
  always_comb begin
    sel_data = '0;
    sel_vol  = '0;
    sel_pan  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (phase == PH_W'(i + 1)) begin
        sel_data = snap_data[i];
        sel_vol  = snap_vol[i];
        sel_pan  = snap_pan[i];
      end
    end
  end

  // (vol+1)/2^VOL_W gives unity gain at full volume.
  assign gain = {1'b0, sel_vol} + (VOL_W + 1)'(1);
  assign prod = PROD_W'(sel_data) * PROD_W'(gain);
  assign term = ACC_W'(prod[PROD_W-1:VOL_W]);

  // The 1-bit sources are taken at phase 0 along with the channel snapshot.
  assign src = (beeper   ? ACC_W'(BEEPER_LVL)   : '0)
             + (tape_out ? ACC_W'(TAPE_OUT_LVL) : '0)
             + (tape_in  ? ACC_W'(TAPE_IN_LVL)  : '0);

  // Seed both sums with the sources, then add each channel to the sides its pan enables.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (phase == '0) begin
      acc <= {src, src};
    end else begin
      for (int s = 0; s < 2; s++)
        if (sel_pan[s]) acc[s] <= acc[s] + term;
    end
  end

  // Clamp the finished sums into the output levels and record any saturation.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      level <= '0;
      clip  <= '0;
    end else if (phase == PH_LATCH) begin
      for (int s = 0; s < 2; s++) begin
        clip[s]  <= (acc[s] > ACC_TOP);
        level[s] <= snap_mute        ? '0 :
                    (acc[s] > ACC_TOP) ? LVL_TOP : acc[s][OUT_W-1:0];
      end
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_sd
    mixer_sd #(.OUT_W(OUT_W)) u_sd (
      .clk28 (clk28),
      .rst_n (rst_n),
      .level (level[s]),
      .dac   (dac[s])
    );
  end

  assign sample_strobe = rst_n && (phase == PH_LATCH);
  assign dac_l         = dac[0];
  assign dac_r         = dac[1];
  assign clip_l        = clip[0];
  assign clip_r        = clip[1];
endmodule

// File: tb/tb_mixer_n.sv
// Bench for mixer_n at its default parameters. A period-level reference
// model computes each period's levels from the inputs present at phase 0,
// then runs the sigma-delta arithmetic. Outputs are compared on every
// negative clock edge. Directed scenarios add literal expectations, and a
// random phase follows them.
module tb_mixer_n;
  localparam int CH   = 4;
  localparam int SW   = 8;
  localparam int VW   = 4;
  localparam int OW   = 10;
  localparam int DIV  = 512;
  localparam int LMAX = (1 << OW) - 1;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  logic [CH*SW-1:0] ch_data = '0;
  logic [CH*VW-1:0] ch_vol  = '0;
  logic [CH*2-1:0]  ch_pan  = '0;
  logic beeper = 1'b0, tape_out = 1'b0, tape_in = 1'b0, mute = 1'b0;
  logic dac_l, dac_r, sample_strobe, clip_l, clip_r;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk28 = ~clk28;

  mixer_n dut (
    .clk28(clk28), .rst_n(rst_n), .ch_data(ch_data), .ch_vol(ch_vol),
    .ch_pan(ch_pan), .beeper(beeper), .tape_out(tape_out), .tape_in(tape_in),
    .mute(mute), .dac_l(dac_l), .dac_r(dac_r), .sample_strobe(sample_strobe),
    .clip_l(clip_l), .clip_r(clip_r)
  );

  // Reference model state
  int m_phase, m_lvl_l, m_lvl_r, m_sd_l, m_sd_r, m_pend_l, m_pend_r, m_sum_l, m_sum_r;
  bit m_dac_l, m_dac_r, m_clip_l, m_clip_r, m_pclip_l, m_pclip_r;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-period result from the inputs present at phase 0
  task automatic model_period();
    int sl, sr, src;
    src = (beeper ? 128 : 0) + (tape_out ? 32 : 0) + (tape_in ? 32 : 0);
    sl = src;
    sr = src;
    for (int c = 0; c < CH; c++) begin
      int t;
      t = int'(ch_data[c*SW +: SW]) * (int'(ch_vol[c*VW +: VW]) + 1) / (1 << VW);
      if (ch_pan[2*c])   sl += t;
      if (ch_pan[2*c+1]) sr += t;
    end
    m_sum_l   = sl;
    m_sum_r   = sr;
    m_pclip_l = (sl > LMAX);
    m_pclip_r = (sr > LMAX);
    m_pend_l  = mute ? 0 : (sl > LMAX ? LMAX : sl);
    m_pend_r  = mute ? 0 : (sr > LMAX ? LMAX : sr);
  endtask

  always @(posedge clk28) begin
    if (!rst_n) begin
      m_phase = 0; m_lvl_l = 0; m_lvl_r = 0; m_sd_l = 0; m_sd_r = 0;
      m_pend_l = 0; m_pend_r = 0; m_dac_l = 0; m_dac_r = 0;
      m_clip_l = 0; m_clip_r = 0; m_pclip_l = 0; m_pclip_r = 0;
    end else begin
      m_dac_l = (m_sd_l + m_lvl_l) >= (1 << OW);
      m_sd_l  = (m_sd_l + m_lvl_l) % (1 << OW);
      m_dac_r = (m_sd_r + m_lvl_r) >= (1 << OW);
      m_sd_r  = (m_sd_r + m_lvl_r) % (1 << OW);
      if (m_phase == 0) model_period();
      if (m_phase == CH + 1) begin
        m_lvl_l  = m_pend_l;
        m_lvl_r  = m_pend_r;
        m_clip_l = m_pclip_l;
        m_clip_r = m_pclip_r;
      end
      m_phase = (m_phase + 1) % DIV;
    end
  end

  // Compare every cycle once reset has taken effect
  always @(negedge clk28) begin
    if (chk_en) begin
      chk("dac_l", dac_l, m_dac_l);
      chk("dac_r", dac_r, m_dac_r);
      chk("sample_strobe", sample_strobe, m_phase == CH + 1);
      chk("clip_l", clip_l, m_clip_l);
      chk("clip_r", clip_r, m_clip_r);
    end
  end

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk28);
      n++;
    end while (m_phase != p && n < 2 * DIV);
    if (m_phase != p) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", p, m_phase);
    end
  endtask

  task automatic count_ones(input int n, output int ol, output int orr);
    ol = 0;
    orr = 0;
    for (int i = 0; i < n; i++) begin
      ol  += int'(dac_l);
      orr += int'(dac_r);
      @(negedge clk28);
    end
  endtask

  task automatic clear_inputs();
    ch_data = '0; ch_vol = '0; ch_pan = '0;
    beeper = 0; tape_out = 0; tape_in = 0; mute = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ol, orr, first, second, k;
    // Reset state
    rst_n = 0;
    repeat (3) @(posedge clk28);
    @(negedge clk28);
    chk_en = 1;
    chk("reset dac_l", dac_l, 1'b0);
    chk("reset dac_r", dac_r, 1'b0);
    chk("reset strobe", sample_strobe, 1'b0);
    rst_n = 1;

    // All inputs 0: silence, strobe every DIV cycles, fifth cycle after release
    ol = 0; orr = 0; first = -1; second = -1;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk28);
      ol  += int'(dac_l);
      orr += int'(dac_r);
      if (sample_strobe) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk_int("idle ones_l", ol, 0);
    chk_int("idle ones_r", orr, 0);
    chk_int("idle first strobe", first, 5);
    chk_int("idle strobe period", second - first, DIV);

    // ch0 full scale, both sides
    wait_phase(0);
    ch_data[0 +: SW] = 8'd255; ch_vol[0 +: VW] = 4'd15; ch_pan[1:0] = 2'b11;
    wait_phase(7);
    count_ones(1024, ol, orr);
    chk_int("full ones_l", ol, 255);
    chk_int("full ones_r", orr, 255);

    // ch1=100 at half volume, left only
    wait_phase(0);
    clear_inputs();
    ch_data[SW +: SW] = 8'd100; ch_vol[VW +: VW] = 4'd7; ch_pan[3:2] = 2'b01;
    wait_phase(7);
    chk_int("model lvl_l 50", m_lvl_l, 50);
    chk_int("model lvl_r 0", m_lvl_r, 0);
    count_ones(1024, ol, orr);
    chk_int("half ones_l", ol, 50);
    chk_int("half ones_r", orr, 0);

    // Saturation, then a silent period clears clip
    wait_phase(0);
    ch_data = '1; ch_vol = '1; ch_pan = '1; beeper = 1;
    wait_phase(7);
    chk_int("model sum 1148", m_sum_l, 1148);
    chk("sat clip_l", clip_l, 1'b1);
    chk("sat clip_r", clip_r, 1'b1);
    count_ones(1024, ol, orr);
    chk_int("sat ones_l", ol, LMAX);
    chk_int("sat ones_r", orr, LMAX);
    wait_phase(0);
    clear_inputs();
    wait_phase(7);
    chk("unsat clip_l", clip_l, 1'b0);
    chk("unsat clip_r", clip_r, 1'b0);

    // ch3 changed at phase 3 (before it is summed), restored before the next snapshot
    wait_phase(0);
    ch_data[3*SW +: SW] = 8'd200; ch_vol[3*VW +: VW] = 4'd15; ch_pan[7:6] = 2'b11;
    wait_phase(3);
    ch_data[3*SW +: SW] = 8'd40;
    wait_phase(7);
    ol = 0; orr = 0;
    for (int i = 0; i < 1024; i++) begin
      ol  += int'(dac_l);
      orr += int'(dac_r);
      if (m_phase == 0) ch_data[3*SW +: SW] = 8'd200;
      @(negedge clk28);
    end
    chk_int("snapshot ones_l", ol, 200);
    chk_int("snapshot ones_r", orr, 200);

    // Mute sampled at phase 0
    wait_phase(0);
    ch_data[0 +: SW] = 8'd255; ch_vol[0 +: VW] = 4'd15; ch_pan[1:0] = 2'b11; mute = 1;
    wait_phase(7);
    count_ones(1024, ol, orr);
    chk_int("mute ones_l", ol, 0);
    chk_int("mute ones_r", orr, 0);

    // Reset mid-period
    wait_phase(0);
    mute = 0;
    wait_phase(200);
    rst_n = 0;
    repeat (3) @(negedge clk28);
    chk("midreset dac_l", dac_l, 1'b0);
    chk("midreset dac_r", dac_r, 1'b0);
    chk("midreset strobe", sample_strobe, 1'b0);
    chk("midreset clip_l", clip_l, 1'b0);
    chk("midreset clip_r", clip_r, 1'b0);
    rst_n = 1;
    k = 0;
    do begin
      @(negedge clk28);
      k++;
    end while (!sample_strobe && k < 20);
    chk_int("strobe after release", k, 5);

    // Random traffic at random phases
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk28);
      if ($urandom_range(0, 39) == 0) begin
        ch_data  = {$urandom, $urandom};
        ch_vol   = 16'($urandom);
        ch_pan   = 8'($urandom);
        beeper   = 1'($urandom);
        tape_out = 1'($urandom);
        tape_in  = 1'($urandom);
        mute     = ($urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
